// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, funct and ALU-op codes plus the packed ALU control word.
// ALU_CTRL_ROR_NATIVE_EN selects which shifter path ROR/RORI use.
package alu_ctrl_pkg;

  // ISA opcodes
  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_SIIC  = 5'b00010;
  localparam logic [4:0] OP_RTI   = 5'b00011;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_RSHF  = 5'b11010;
  localparam logic [4:0] OP_RARI  = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_SUB  = 2'b01;
  localparam logic [1:0] FN_XOR  = 2'b10;
  localparam logic [1:0] FN_ANDN = 2'b11;
  localparam logic [1:0] FN_ROL  = 2'b00;
  localparam logic [1:0] FN_SLL  = 2'b01;
  localparam logic [1:0] FN_ROR  = 2'b10;
  localparam logic [1:0] FN_SRL  = 2'b11;

  localparam logic [2:0] ALU_ROL = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_ROR = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       inv_a;
    logic       inv_b;
    logic       cin;
    logic       sign;
    logic       ror_sel;
  } ctrl_t;

  function automatic ctrl_t make_ctrl(input logic [2:0] op, input logic ia, input logic ib,
                                      input logic ci, input logic sg, input logic rs);
    ctrl_t c;
    c.alu_op  = op;
    c.inv_a   = ia;
    c.inv_b   = ib;
    c.cin     = ci;
    c.sign    = sg;
    c.ror_sel = rs;
    return c;
  endfunction

  localparam ctrl_t CTRL_PLAIN = '{alu_op: ALU_ADD, inv_a: 1'b0, inv_b: 1'b0, cin: 1'b0, sign: 1'b0, ror_sel: 1'b0};
  localparam ctrl_t CTRL_RESET = CTRL_PLAIN;

endpackage

// File: rtl/alu_ctrl_lut.sv
// Combinational (opCode, funct) -> ALU control decode.
// ALU_CTRL_ROR_NATIVE_EN routes ROR/RORI to the native ror op instead of rol+rorSel.
module alu_ctrl_lut
  import alu_ctrl_pkg::*;
(
  input  logic [4:0] op_code,
  input  logic [1:0] funct,
  output ctrl_t      ctrl
);

  ctrl_t c_sadd, c_sub, c_xor, c_andn, c_rol, c_sll, c_ror, c_srl, c_cmp, c_or;

  always_comb begin
    c_sadd = make_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    c_sub  = make_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    c_xor  = make_ctrl(ALU_XOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    c_andn = make_ctrl(ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    c_rol  = make_ctrl(ALU_ROL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    c_sll  = make_ctrl(ALU_SLL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_CTRL_ROR_NATIVE_EN
    c_ror  = make_ctrl(ALU_ROR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    // Rotate-right borrows the rol shifter; rorSel tells the ALU to reverse direction
    c_ror  = make_ctrl(ALU_ROL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    c_srl  = make_ctrl(ALU_SRL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    c_cmp  = make_ctrl(ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    c_or   = make_ctrl(ALU_OR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  end

  always_comb begin
    ctrl = CTRL_PLAIN;
    case (op_code)
      OP_HALT, OP_NOP, OP_SIIC, OP_RTI, OP_BTR, OP_SCO: ctrl = CTRL_PLAIN;
      OP_J, OP_JR, OP_JAL, OP_JALR,
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ,
      OP_ST, OP_LD, OP_STU, OP_LBI, OP_ADDI:           ctrl = c_sadd;
      OP_SUBI:                                          ctrl = c_sub;
      OP_XORI:                                          ctrl = c_xor;
      OP_ANDNI:                                         ctrl = c_andn;
      OP_SLBI:                                          ctrl = c_or;
      OP_ROLI:                                          ctrl = c_rol;
      OP_SLLI:                                          ctrl = c_sll;
      OP_RORI:                                          ctrl = c_ror;
      OP_SRLI:                                          ctrl = c_srl;
      OP_SEQ, OP_SLT, OP_SLE:                           ctrl = c_cmp;
      OP_RARI: begin
        case (funct)
          FN_ADD:  ctrl = c_sadd;
          FN_SUB:  ctrl = c_sub;
          FN_XOR:  ctrl = c_xor;
          default: ctrl = c_andn;
        endcase
      end
      OP_RSHF: begin
        case (funct)
          FN_ROL:  ctrl = c_rol;
          FN_SLL:  ctrl = c_sll;
          FN_ROR:  ctrl = c_ror;
          default: ctrl = c_srl;
        endcase
      end
      default: ctrl = CTRL_PLAIN;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decode.sv
// Registered ALU control decode: one clock of latency, async active-low reset.
// Build option ALU_CTRL_ROR_NATIVE_EN is handled inside alu_ctrl_lut.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opCode,
  input  logic [1:0] funct,
  output logic [2:0] aluOp,
  output logic       invA,
  output logic       invB,
  output logic       Cin,
  output logic       sign,
  output logic       rorSel
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  alu_ctrl_lut u_lut (
    .op_code (opCode),
    .funct   (funct),
    .ctrl    (ctrl_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ctrl_q <= CTRL_RESET;
    else      ctrl_q <= ctrl_d;
  end

  assign aluOp  = ctrl_q.alu_op;
  assign invA   = ctrl_q.inv_a;
  assign invB   = ctrl_q.inv_b;
  assign Cin    = ctrl_q.cin;
  assign sign   = ctrl_q.sign;
  assign rorSel = ctrl_q.ror_sel;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Directed bench for alu_ctrl_decode with hand-computed control words.
// Honours ALU_CTRL_ROR_NATIVE_EN for the rotate-right expectations.
module tb_alu_ctrl_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] op_code;
  logic [1:0] funct;
  logic [2:0] alu_op;
  logic       inv_a, inv_b, cin, sign, ror_sel;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Expected words {aluOp, invA, invB, Cin, sign, rorSel}
  localparam logic [7:0] E_PLAIN = 8'b100_0_0_0_0_0;
  localparam logic [7:0] E_SADD  = 8'b100_0_0_0_1_0;
  localparam logic [7:0] E_SUB   = 8'b100_1_0_1_1_0;
  localparam logic [7:0] E_XOR   = 8'b110_0_0_0_0_0;
  localparam logic [7:0] E_ANDN  = 8'b111_0_1_0_0_0;
  localparam logic [7:0] E_ROL   = 8'b000_0_0_0_0_0;
  localparam logic [7:0] E_SLL   = 8'b001_0_0_0_0_0;
`ifdef ALU_CTRL_ROR_NATIVE_EN
  localparam logic [7:0] E_ROR   = 8'b010_0_0_0_0_0;
`else
  localparam logic [7:0] E_ROR   = 8'b000_0_0_0_0_1;
`endif
  localparam logic [7:0] E_SRL   = 8'b011_0_0_0_0_0;
  localparam logic [7:0] E_CMP   = 8'b100_0_1_1_1_0;
  localparam logic [7:0] E_OR    = 8'b101_0_0_0_0_0;

  alu_ctrl_decode dut (
    .clk    (clk),
    .rst    (rst),
    .opCode (op_code),
    .funct  (funct),
    .aluOp  (alu_op),
    .invA   (inv_a),
    .invB   (inv_b),
    .Cin    (cin),
    .sign   (sign),
    .rorSel (ror_sel)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic [4:0] op, input logic [1:0] fn);
    @(negedge clk);
    op_code = op;
    funct   = fn;
  endtask

  task automatic check_output(input string tag, input logic [7:0] exp);
    logic [14:0] obs_w, exp_w;
    obs_w = {op_code, funct, alu_op, inv_a, inv_b, cin, sign, ror_sel};
    exp_w = {op_code, funct, exp};
    n_compared++;
    assert (obs_w === exp_w) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %b required %b", tag, obs_w, exp_w);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] op, input logic [1:0] fn,
                      input logic [7:0] exp);
    apply_stimulus(op, fn);
    @(posedge clk);
    #1;
    check_output(tag, exp);
  endtask

  logic [14:0] vec [38];

  initial begin
    vec = '{
      {5'b01000, 2'b10, E_SADD}, {5'b11011, 2'b00, E_SADD},
      {5'b01001, 2'b11, E_SUB},  {5'b11011, 2'b01, E_SUB},
      {5'b01010, 2'b00, E_XOR},  {5'b11011, 2'b10, E_XOR},
      {5'b01011, 2'b01, E_ANDN}, {5'b11011, 2'b11, E_ANDN},
      {5'b10100, 2'b11, E_ROL},  {5'b11010, 2'b00, E_ROL},
      {5'b10101, 2'b10, E_SLL},  {5'b11010, 2'b01, E_SLL},
      {5'b10110, 2'b01, E_ROR},  {5'b11010, 2'b10, E_ROR},
      {5'b10111, 2'b00, E_SRL},  {5'b11010, 2'b11, E_SRL},
      {5'b11100, 2'b00, E_CMP},  {5'b11101, 2'b01, E_CMP},
      {5'b11110, 2'b10, E_CMP},  {5'b11111, 2'b11, E_PLAIN},
      {5'b10010, 2'b00, E_OR},
      {5'b10000, 2'b01, E_SADD}, {5'b10001, 2'b10, E_SADD},
      {5'b10011, 2'b11, E_SADD}, {5'b01100, 2'b00, E_SADD},
      {5'b01101, 2'b01, E_SADD}, {5'b01110, 2'b10, E_SADD},
      {5'b01111, 2'b11, E_SADD}, {5'b00100, 2'b00, E_SADD},
      {5'b00101, 2'b01, E_SADD}, {5'b00110, 2'b10, E_SADD},
      {5'b00111, 2'b11, E_SADD}, {5'b11000, 2'b00, E_SADD},
      {5'b00000, 2'b01, E_PLAIN}, {5'b00001, 2'b10, E_PLAIN},
      {5'b00010, 2'b11, E_PLAIN}, {5'b00011, 2'b00, E_PLAIN},
      {5'b11001, 2'b01, E_PLAIN}
    };

    // Reset held across edges with a non-default opcode driven
    rst     = 1'b0;
    op_code = 5'b01001;
    funct   = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hold", E_PLAIN);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("first_edge_after_reset", E_SUB);

    for (int i = 0; i < 38; i++)
      step($sformatf("sweep_%0d", i), vec[i][14:10], vec[i][9:8], vec[i][7:0]);

    step("rori", 5'b10110, 2'b00, E_ROR);
    step("ror_r", 5'b11010, 2'b10, E_ROR);

    for (int f = 0; f < 4; f++)
      step($sformatf("addi_funct_%0d", f), 5'b01000, 2'(f), E_SADD);

    step("slt", 5'b11101, 2'b00, E_CMP);
    step("sco", 5'b11111, 2'b00, E_PLAIN);
    step("xor_before_reset", 5'b11011, 2'b10, E_XOR);

    // Async reset between edges must act without waiting for a clock
    #2;
    rst = 1'b0;
    #1;
    check_output("async_reset_mid", E_PLAIN);
    @(posedge clk);
    #1;
    check_output("async_reset_held", E_PLAIN);
    @(negedge clk);
    rst = 1'b1;
    step("after_mid_reset", 5'b01011, 2'b00, E_ANDN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed no finish required finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
